// File: rtl/bd_fetch_pkg.sv
// -----------------------------------------------------------------------------
// bd_fetch_pkg
// Shared definitions for the BD fetch scheduler:
//   - fetch_state_t : scheduler FSM encoding (IDLE / ISSUE / WAIT_CPL)
//   - BD / page geometry and bus field widths
//   - page_bd_room(): number of whole BDs that fit between an address and the
//     next 4KB boundary (a memory read must never cross a 4KB page)
// -----------------------------------------------------------------------------
package bd_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_CPL = 2'd2
  } fetch_state_t;

  localparam int BD_BYTES   = 32;
  localparam int PAGE_BYTES = 4096;
  localparam int TAG_W      = 8;
  localparam int DW_PER_BD  = 8;
  localparam int CH_ID_W    = 3;
  localparam int BD_NUM_W   = 4;
  localparam int ADDR_W     = 64;
  localparam int DW_CNT_W   = 11;

  // BDs left in the current 4KB page starting at page offset page_off.
  // Result is 1..128 for a 32B aligned offset.
  function automatic logic [7:0] page_bd_room(input logic [11:0] page_off);
    logic [12:0] bytes_left;
    bytes_left = 13'(PAGE_BYTES) - {1'b0, page_off};
    return bytes_left[12:5];
  endfunction

endpackage

// File: rtl/bd_fetch_sched_if.sv
// -----------------------------------------------------------------------------
// bd_fetch_sched_if
// Memory-read descriptor channel from the BD fetch scheduler to the RQ request
// generator.
//   rq_rd_valid   descriptor valid (scheduler -> RQ generator)
//   rq_rd_ready   descriptor accepted (RQ generator -> scheduler)
//   rq_rd_addr    64-bit read address
//   rq_rd_dw_cnt  read length in DW
//   rq_rd_tag     {5'b0, channel id}
// Modports: master = scheduler side, slave = RQ generator side.
// -----------------------------------------------------------------------------
interface bd_fetch_sched_if;
  import bd_fetch_pkg::*;

  logic                rq_rd_valid;
  logic                rq_rd_ready;
  logic [ADDR_W-1:0]   rq_rd_addr;
  logic [DW_CNT_W-1:0] rq_rd_dw_cnt;
  logic [TAG_W-1:0]    rq_rd_tag;

  modport master (
    output rq_rd_valid,
    output rq_rd_addr,
    output rq_rd_dw_cnt,
    output rq_rd_tag,
    input  rq_rd_ready
  );

  modport slave (
    input  rq_rd_valid,
    input  rq_rd_addr,
    input  rq_rd_dw_cnt,
    input  rq_rd_tag,
    output rq_rd_ready
  );

endinterface

// File: rtl/bd_fetch_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted request at or after ptr
// (wrapping at NUM_CH) wins.
//   req      in   NUM_CH  request vector
//   ptr      in   ID_W    highest-priority channel this cycle
//   gnt      out  NUM_CH  one-hot grant (all zero when no request)
//   gnt_id   out  ID_W    encoded grant
//   gnt_any  out  1       at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 3
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [ID_W-1:0]   gnt_id,
  output logic              gnt_any
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  always_comb begin
    int               sum;
    logic [IDX_W-1:0] idx;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    sum     = 0;
    idx     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // Scan from ptr upward with wrap-around; the first hit is kept.
      sum = int'(ptr) + i;
      if (sum >= NUM_CH) sum = sum - NUM_CH;
      idx = IDX_W'(sum);
      if (!gnt_any && req[idx]) begin
        gnt_any  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(sum);
      end
    end
  end

endmodule

// File: rtl/bd_fetch_sched.sv
// -----------------------------------------------------------------------------
// bd_fetch_sched
// BD fetch scheduler for the multi-channel PCIe DMA engine. Round-robin picks
// one channel's BD-fetch request, issues a single memory-read descriptor to the
// RQ generator, exports the BD count of that fetch to the completion receiver,
// waits for the final completion beat and reports done to the channel. Only one
// fetch is ever in flight, so bd_size_for_cpld is stable for a whole fetch.
//
// Ports:
//   user_clk, user_reset_n        clock / async active-low reset
//   ch_req_valid/ready            per-channel request, one-hot 1-cycle accept
//   ch_req_addr, ch_req_bd_num    per-channel BD address (32B aligned), count
//   ch_grant_bd_num               BDs actually fetched (clipped at 4KB page)
//   rq (bd_fetch_sched_if.master) read descriptor to the RQ generator
//   bd_size_for_cpld              BD count of the in-flight fetch
//   cpld_done                     last completion beat of the fetch
//   ch_done_valid/id/err          1-cycle completion report (err = aborted)
//   busy                          scheduler not idle
//
// Build option: define BD_FETCH_TIMEOUT_EN to add a WAIT_CPL watchdog that
// aborts a fetch after TIMEOUT_CYCLES cycles without cpld_done.
// -----------------------------------------------------------------------------
module bd_fetch_sched
  import bd_fetch_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       user_clk,
  input  logic                       user_reset_n,
  input  logic [NUM_CH-1:0]          ch_req_valid,
  output logic [NUM_CH-1:0]          ch_req_ready,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_req_addr,
  input  logic [NUM_CH*BD_NUM_W-1:0] ch_req_bd_num,
  output logic [BD_NUM_W-1:0]        ch_grant_bd_num,
  bd_fetch_sched_if.master           rq,
  output logic [BD_NUM_W-1:0]        bd_size_for_cpld,
  input  logic                       cpld_done,
  output logic                       ch_done_valid,
  output logic [CH_ID_W-1:0]         ch_done_id,
  output logic                       ch_done_err,
  output logic                       busy
);

  if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
    $error("bd_fetch_sched: NUM_CH must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("bd_fetch_sched: TIMEOUT_CYCLES must fit the 16-bit watchdog");
  end

  // Clip a request so the read stays inside one 4KB page.
  function automatic logic [BD_NUM_W-1:0] clamp_to_page(
    input logic [BD_NUM_W-1:0] want,
    input logic [7:0]          room
  );
    return ({4'b0, want} > room) ? room[BD_NUM_W-1:0] : want;
  endfunction

  fetch_state_t state_q, state_d;

  logic                arm_q;
  logic [CH_ID_W-1:0]  rr_ptr_q;
  logic [NUM_CH-1:0]   gnt_oh;
  logic [CH_ID_W-1:0]  gnt_id;
  logic                gnt_any;
  logic [ADDR_W-1:0]   sel_addr;
  logic [BD_NUM_W-1:0] sel_bd_num;
  logic [BD_NUM_W-1:0] fetched_sel;

  logic                accept;
  logic                issue_start;
  logic                wait_start;
  logic                done_set;
  logic                done_err_set;
  logic [CH_ID_W-1:0]  done_id_set;
  logic                wdog_expire;

  logic [ADDR_W-1:0]   addr_p1;
  logic [BD_NUM_W-1:0] fetched_p1;
  logic [CH_ID_W-1:0]  ch_id_p1;
  logic                done_vld_p1;
  logic                done_err_p1;
  logic [CH_ID_W-1:0]  done_id_p1;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .ID_W   (CH_ID_W)
  ) u_rr_arbiter (
    .req     (ch_req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt_oh),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  always_comb begin
    sel_addr   = '0;
    sel_bd_num = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_oh[i]) begin
        sel_addr   = ch_req_addr[i*ADDR_W +: ADDR_W];
        sel_bd_num = ch_req_bd_num[i*BD_NUM_W +: BD_NUM_W];
      end
    end
  end

  assign fetched_sel = clamp_to_page(sel_bd_num, page_bd_room(sel_addr[11:0]));

  // FSM next state. Arbitration is suppressed while a done pulse is on the
  // wire so a channel never sees its done and a new accept in the same cycle.
  // arm_q keeps the Mealy ready output quiet until the first clock after reset.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    issue_start  = 1'b0;
    wait_start   = 1'b0;
    done_set     = 1'b0;
    done_err_set = 1'b0;
    done_id_set  = ch_id_p1;
    case (state_q)
      ST_IDLE: begin
        if (arm_q && !done_vld_p1 && gnt_any) begin
          accept = 1'b1;
          if (sel_bd_num == '0) begin
            // Nothing to fetch: accept and report an error, no read issued.
            done_set     = 1'b1;
            done_err_set = 1'b1;
            done_id_set  = gnt_id;
          end else begin
            issue_start = 1'b1;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (rq.rq_rd_ready) begin
          wait_start = 1'b1;
          state_d    = ST_WAIT_CPL;
        end
      end
      ST_WAIT_CPL: begin
        // A completion landing in the expiry cycle takes priority.
        if (cpld_done) begin
          done_set = 1'b1;
          state_d  = ST_IDLE;
        end else if (wdog_expire) begin
          done_set     = 1'b1;
          done_err_set = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) state_q <= ST_IDLE;
    else               state_q <= state_d;
  end

  // p0 -> p1: latch the accepted request and the done report
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      arm_q       <= 1'b0;
      rr_ptr_q    <= '0;
      addr_p1     <= '0;
      fetched_p1  <= '0;
      ch_id_p1    <= '0;
      done_vld_p1 <= 1'b0;
      done_err_p1 <= 1'b0;
      done_id_p1  <= '0;
    end else begin
      arm_q <= 1'b1;
      if (accept) begin
        rr_ptr_q <= (gnt_id == CH_ID_W'(NUM_CH - 1)) ? '0 : gnt_id + 1'b1;
      end
      if (issue_start) begin
        addr_p1    <= sel_addr;
        fetched_p1 <= fetched_sel;
        ch_id_p1   <= gnt_id;
      end
      done_vld_p1 <= done_set;
      done_err_p1 <= done_err_set;
      if (done_set) done_id_p1 <= done_id_set;
    end
  end

`ifdef BD_FETCH_TIMEOUT_EN
  logic [15:0] wdog_q;

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n)                wdog_q <= '0;
    else if (wait_start)              wdog_q <= '0;
    else if (state_q == ST_WAIT_CPL)  wdog_q <= wdog_q + 1'b1;
  end

  // wdog_q counts WAIT_CPL cycles from 0, so the abort pulse lands exactly
  // TIMEOUT_CYCLES cycles after WAIT_CPL entry.
  assign wdog_expire = (state_q == ST_WAIT_CPL) && (wdog_q == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_wait_start;
  assign unused_wait_start = wait_start;
  assign wdog_expire       = 1'b0;
`endif

  assign ch_req_ready     = accept ? gnt_oh : '0;
  assign ch_grant_bd_num  = accept ? fetched_sel : '0;

  assign rq.rq_rd_valid   = (state_q == ST_ISSUE);
  assign rq.rq_rd_addr    = addr_p1;
  assign rq.rq_rd_dw_cnt  = {3'b0, fetched_p1, 3'b0};
  assign rq.rq_rd_tag     = {5'b0, ch_id_p1};

  assign bd_size_for_cpld = fetched_p1;
  assign ch_done_valid    = done_vld_p1;
  assign ch_done_err      = done_err_p1;
  assign ch_done_id       = done_id_p1;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bd_fetch_sched.sv
// -----------------------------------------------------------------------------
// tb_bd_fetch_sched
// Directed bench for bd_fetch_sched: reset values, round-robin order, 4KB page
// clipping, descriptor stall, zero-BD request, stray cpld_done, async reset in
// WAIT_CPL and WAIT_CPL behaviour with and without BD_FETCH_TIMEOUT_EN.
// Inputs change just after the falling edge; outputs are checked there too.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bd_fetch_sched;
  import bd_fetch_pkg::*;

  localparam int NUM_CH = 4;

  logic                 user_clk = 1'b0;
  logic                 user_reset_n;
  logic [NUM_CH-1:0]    ch_req_valid;
  logic [NUM_CH-1:0]    ch_req_ready;
  logic [NUM_CH*64-1:0] ch_req_addr;
  logic [NUM_CH*4-1:0]  ch_req_bd_num;
  logic [3:0]           ch_grant_bd_num;
  logic [3:0]           bd_size_for_cpld;
  logic                 cpld_done;
  logic                 ch_done_valid;
  logic [2:0]           ch_done_id;
  logic                 ch_done_err;
  logic                 busy;

  int n_chk = 0;
  int n_err = 0;
  int xfer_cnt = 0;
  int x0;
  int k;

  bd_fetch_sched_if rq_if();

  always #5 user_clk = ~user_clk;

  bd_fetch_sched #(
    .NUM_CH         (NUM_CH),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .user_clk         (user_clk),
    .user_reset_n     (user_reset_n),
    .ch_req_valid     (ch_req_valid),
    .ch_req_ready     (ch_req_ready),
    .ch_req_addr      (ch_req_addr),
    .ch_req_bd_num    (ch_req_bd_num),
    .ch_grant_bd_num  (ch_grant_bd_num),
    .rq               (rq_if),
    .bd_size_for_cpld (bd_size_for_cpld),
    .cpld_done        (cpld_done),
    .ch_done_valid    (ch_done_valid),
    .ch_done_id       (ch_done_id),
    .ch_done_err      (ch_done_err),
    .busy             (busy)
  );

  always @(posedge user_clk) begin
    if (rq_if.rq_rd_valid && rq_if.rq_rd_ready) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge user_clk);
    #1;
  endtask

  task automatic set_req(input int ch, input logic v, input logic [63:0] a, input logic [3:0] n);
    ch_req_valid[ch]          = v;
    ch_req_addr[ch*64 +: 64]  = a;
    ch_req_bd_num[ch*4 +: 4]  = n;
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    #1;
    while (ch_req_ready == '0 && w < 20) begin
      step();
      w++;
    end
    if (ch_req_ready == '0) check_val("wait_ready_timeout", 64'(0), 64'(1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_ready"},   64'(ch_req_ready),          64'(0));
    check_val({tag, "_grant"},   64'(ch_grant_bd_num),       64'(0));
    check_val({tag, "_rqvld"},   64'(rq_if.rq_rd_valid),     64'(0));
    check_val({tag, "_rqaddr"},  rq_if.rq_rd_addr,           64'(0));
    check_val({tag, "_rqdw"},    64'(rq_if.rq_rd_dw_cnt),    64'(0));
    check_val({tag, "_rqtag"},   64'(rq_if.rq_rd_tag),       64'(0));
    check_val({tag, "_bdsize"},  64'(bd_size_for_cpld),      64'(0));
    check_val({tag, "_donev"},   64'(ch_done_valid),         64'(0));
    check_val({tag, "_doneid"},  64'(ch_done_id),            64'(0));
    check_val({tag, "_doneerr"}, 64'(ch_done_err),           64'(0));
    check_val({tag, "_busy"},    64'(busy),                  64'(0));
  endtask

  // One complete fetch with rq_rd_ready high: accept, ISSUE, WAIT_CPL, done.
  task automatic run_fetch(input int g, input logic [63:0] a, input logic [3:0] n);
    int xs;
    xs = xfer_cnt;
    wait_ready();
    check_val($sformatf("ready_ch%0d", g), 64'(ch_req_ready), 64'(1 << g));
    check_val($sformatf("grant_n_ch%0d", g), 64'(ch_grant_bd_num), 64'(n));
    step();
    check_val($sformatf("rq_valid_ch%0d", g), 64'(rq_if.rq_rd_valid), 64'(1));
    check_val($sformatf("rq_addr_ch%0d", g), rq_if.rq_rd_addr, a);
    check_val($sformatf("rq_dw_ch%0d", g), 64'(rq_if.rq_rd_dw_cnt), 64'(n) * 64'd8);
    check_val($sformatf("rq_tag_ch%0d", g), 64'(rq_if.rq_rd_tag), 64'(g));
    check_val($sformatf("bd_size_ch%0d", g), 64'(bd_size_for_cpld), 64'(n));
    step();
    check_val($sformatf("wait_busy_ch%0d", g), 64'({rq_if.rq_rd_valid, busy}), 64'(1));
    cpld_done = 1'b1;
    step();
    cpld_done = 1'b0;
    check_val($sformatf("done_v_ch%0d", g), 64'(ch_done_valid), 64'(1));
    check_val($sformatf("done_id_ch%0d", g), 64'(ch_done_id), 64'(g));
    check_val($sformatf("done_err_ch%0d", g), 64'(ch_done_err), 64'(0));
    check_val($sformatf("no_arb_on_done_ch%0d", g), 64'(ch_req_ready), 64'(0));
    check_val($sformatf("xfers_ch%0d", g), 64'(xfer_cnt - xs), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    user_reset_n      = 1'b0;
    ch_req_valid      = '0;
    ch_req_addr       = '0;
    ch_req_bd_num     = '0;
    cpld_done         = 1'b0;
    rq_if.rq_rd_ready = 1'b1;

    // Reset state, with a request already pending.
    set_req(0, 1'b1, 64'h1_0000_0000, 4'd4);
    repeat (3) step();
    check_idle_outputs("rst");

    // Round robin: all four channels keep requesting 4 BDs.
    for (int i = 0; i < NUM_CH; i++) set_req(i, 1'b1, 64'h1_0000_0000 + 64'(i) * 64'h1000, 4'd4);
    user_reset_n = 1'b1;
    run_fetch(0, 64'h1_0000_0000, 4'd4);
    run_fetch(1, 64'h1_0000_1000, 4'd4);
    run_fetch(2, 64'h1_0000_2000, 4'd4);
    run_fetch(3, 64'h1_0000_3000, 4'd4);
    run_fetch(0, 64'h1_0000_0000, 4'd4);
    ch_req_valid = '0;

    // 4KB clip: 0x1FC0 leaves 2 BDs in the page; 0x2FE0 leaves 1.
    set_req(2, 1'b1, 64'h1FC0, 4'd8);
    run_fetch(2, 64'h1FC0, 4'd2);
    ch_req_valid = '0;
    set_req(3, 1'b1, 64'h2FE0, 4'd15);
    run_fetch(3, 64'h2FE0, 4'd1);
    ch_req_valid = '0;

    // Descriptor stall: ready low for 5 ISSUE clock edges.
    rq_if.rq_rd_ready = 1'b0;
    x0 = xfer_cnt;
    set_req(1, 1'b1, 64'h0000_00AB_CDEF_0040, 4'd3);
    wait_ready();
    check_val("stall_ready", 64'(ch_req_ready), 64'(4'b0010));
    check_val("stall_grant", 64'(ch_grant_bd_num), 64'(3));
    for (int c = 0; c < 6; c++) begin
      step();
      ch_req_valid[1] = 1'b0;
      check_val($sformatf("stall_vld_%0d", c), 64'(rq_if.rq_rd_valid), 64'(1));
      check_val($sformatf("stall_addr_%0d", c), rq_if.rq_rd_addr, 64'h0000_00AB_CDEF_0040);
      check_val($sformatf("stall_dw_%0d", c), 64'(rq_if.rq_rd_dw_cnt), 64'(24));
      check_val($sformatf("stall_tag_%0d", c), 64'(rq_if.rq_rd_tag), 64'(1));
      check_val($sformatf("stall_noxfer_%0d", c), 64'(xfer_cnt - x0), 64'(0));
    end
    rq_if.rq_rd_ready = 1'b1;
    step();
    check_val("stall_xfer_once", 64'(xfer_cnt - x0), 64'(1));
    check_val("stall_vld_drop", 64'(rq_if.rq_rd_valid), 64'(0));
    check_val("stall_busy", 64'(busy), 64'(1));
    cpld_done = 1'b1;
    step();
    cpld_done = 1'b0;
    check_val("stall_done_v", 64'(ch_done_valid), 64'(1));
    check_val("stall_done_id", 64'(ch_done_id), 64'(1));

    // Zero-BD request: accepted, error done, no read.
    x0 = xfer_cnt;
    set_req(1, 1'b1, 64'h3000, 4'd0);
    wait_ready();
    check_val("zero_ready", 64'(ch_req_ready), 64'(4'b0010));
    check_val("zero_grant", 64'(ch_grant_bd_num), 64'(0));
    step();
    ch_req_valid[1] = 1'b0;
    check_val("zero_done_v", 64'(ch_done_valid), 64'(1));
    check_val("zero_done_err", 64'(ch_done_err), 64'(1));
    check_val("zero_done_id", 64'(ch_done_id), 64'(1));
    check_val("zero_no_rq", 64'(rq_if.rq_rd_valid), 64'(0));
    check_val("zero_busy", 64'(busy), 64'(0));
    check_val("zero_bdsize_held", 64'(bd_size_for_cpld), 64'(3));
    step();
    check_val("zero_pulse_end", 64'(ch_done_valid), 64'(0));
    check_val("zero_no_xfer", 64'(xfer_cnt - x0), 64'(0));

    // Stray cpld_done while idle is ignored.
    cpld_done = 1'b1;
    step();
    cpld_done = 1'b0;
    check_val("stray_cpl_done_v", 64'(ch_done_valid), 64'(0));
    check_val("stray_cpl_busy", 64'(busy), 64'(0));

    // Async reset while in WAIT_CPL.
    set_req(0, 1'b1, 64'h5000, 4'd5);
    wait_ready();
    check_val("mid_ready", 64'(ch_req_ready), 64'(4'b0001));
    step();
    step();
    check_val("mid_busy", 64'(busy), 64'(1));
    set_req(1, 1'b1, 64'h7000, 4'd2);
    #2;
    user_reset_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    step();
    user_reset_n = 1'b1;
    // ch0 and ch1 both request; pointer back at 0 picks ch0.
    run_fetch(0, 64'h5000, 4'd5);
    ch_req_valid = '0;

`ifdef BD_FETCH_TIMEOUT_EN
    set_req(2, 1'b1, 64'h6000, 4'd2);
    wait_ready();
    check_val("to_ready", 64'(ch_req_ready), 64'(4'b0100));
    step();
    ch_req_valid = '0;
    step();
    k = 0;
    while (!ch_done_valid && k < 300) begin
      step();
      k++;
    end
    check_val("to_cycles", 64'(k), 64'(100));
    check_val("to_err", 64'(ch_done_err), 64'(1));
    check_val("to_id", 64'(ch_done_id), 64'(2));
    check_val("to_idle", 64'(busy), 64'(0));
`else
    set_req(2, 1'b1, 64'h6000, 4'd2);
    wait_ready();
    check_val("nto_ready", 64'(ch_req_ready), 64'(4'b0100));
    step();
    ch_req_valid = '0;
    k = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (ch_done_valid) k++;
    end
    check_val("nto_no_done", 64'(k), 64'(0));
    check_val("nto_still_busy", 64'(busy), 64'(1));
    cpld_done = 1'b1;
    step();
    cpld_done = 1'b0;
    check_val("nto_done_v", 64'(ch_done_valid), 64'(1));
    check_val("nto_done_err", 64'(ch_done_err), 64'(0));
    check_val("nto_done_id", 64'(ch_done_id), 64'(2));
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
